// File: rtl/axi_llc_pkg.sv
// Shared widths and the miss-counter descriptor layout for the LLC miss-pipeline
// counter bank.
package axi_llc_pkg;

  localparam int unsigned AxiIdWidth  = 4;
  localparam int unsigned DefIdBits   = 2;
  localparam int unsigned DefCntWidth = 4;
  localparam int unsigned DefOrdWidth = 5;

  // rw: 0 = read, 1 = write
  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic                  rw;
    logic                  valid;
  } miss_cnt_t;

endpackage

// File: rtl/axi_llc_sat_counter.sv
// Saturating up/down counter. Simultaneous inc and dec cancel. A dec at zero
// leaves the count at zero and pulses underflow_o in that cycle.
module axi_llc_sat_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] q_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             underflow_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] q_q, q_d;

  assign full_o  = &q_q;
  assign empty_o = ~|q_q;
  assign q_o     = q_q;

  always_comb begin
    q_d         = q_q;
    underflow_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (!full_o) q_d = q_q + One;
      end
      2'b01: begin
        if (empty_o) underflow_o = 1'b1;
        else         q_d = q_q - One;
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

endmodule

// File: rtl/axi_llc_miss_cnt_bank.sv
// Per-ID outstanding-miss counters plus optional global write/read ordering
// counters; decides whether an incoming descriptor must follow the miss pipeline.
module axi_llc_miss_cnt_bank
  import axi_llc_pkg::*;
#(
  parameter int unsigned IdBits     = DefIdBits,
  parameter int unsigned CntWidth   = DefCntWidth,
  parameter int unsigned OrdWidth   = DefOrdWidth,
  parameter bit          WriteOrder = 1'b1,
  parameter bit          ReadOrder  = 1'b0,
  parameter type         cnt_t      = miss_cnt_t,
  localparam int unsigned NoCnt     = 2**IdBits
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  cnt_t                            cnt_up_i,
  input  cnt_t                            cnt_down_i,
  output logic                            to_miss_o,
  output logic                            stall_o,
  output logic                            idle_o,
  output logic                            underflow_o,
  output logic [NoCnt-1:0][CntWidth-1:0]  cnt_q_o,
  output logic [OrdWidth-1:0]             w_cnt_q_o,
  output logic [OrdWidth-1:0]             r_cnt_q_o
);

  if (IdBits < 1) begin : gen_chk_id_bits
    $error("IdBits must be >= 1");
  end
  if (CntWidth < 1) begin : gen_chk_cnt_width
    $error("CntWidth must be >= 1");
  end
  if (OrdWidth < 1) begin : gen_chk_ord_width
    $error("OrdWidth must be >= 1");
  end
  if ($bits(cnt_up_i.id) < IdBits) begin : gen_chk_id_field
    $error("cnt_t id field narrower than IdBits");
  end

  logic [IdBits-1:0] up_idx, dn_idx;
  logic              up_accept;
  logic [NoCnt-1:0]  id_inc, id_dec, id_full, id_empty, id_uf;
  logic              w_inc, w_dec, w_full, w_empty, w_uf;
  logic              r_inc, r_dec, r_full, r_empty, r_uf;
  logic              ord_full, ord_busy;
  logic              underflow_q, underflow_d;
  logic              unused_id_bits;

  assign up_idx = cnt_up_i.id[IdBits-1:0];
  assign dn_idx = cnt_down_i.id[IdBits-1:0];
  assign unused_id_bits = ^{cnt_up_i.id, cnt_down_i.id};

  // A disabled ordering counter never moves, so it stays empty and never full.
  assign ord_full = cnt_up_i.rw ? (WriteOrder && w_full)   : (ReadOrder && r_full);
  assign ord_busy = cnt_up_i.rw ? (WriteOrder && !w_empty) : (ReadOrder && !r_empty);

  assign stall_o   = cnt_up_i.valid && (id_full[up_idx] || ord_full);
  assign to_miss_o = cnt_up_i.valid && (!id_empty[up_idx] || ord_busy);
  assign up_accept = cnt_up_i.valid && !stall_o;

  for (genvar i = 0; i < NoCnt; i++) begin : gen_id_cnt
    assign id_inc[i] = up_accept && (up_idx == IdBits'(i));
    assign id_dec[i] = cnt_down_i.valid && (dn_idx == IdBits'(i));

    axi_llc_sat_counter #(
      .Width (CntWidth)
    ) i_id_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (id_inc[i]),
      .dec_i       (id_dec[i]),
      .q_o         (cnt_q_o[i]),
      .full_o      (id_full[i]),
      .empty_o     (id_empty[i]),
      .underflow_o (id_uf[i])
    );
  end

  assign w_inc = WriteOrder && up_accept && cnt_up_i.rw;
  assign w_dec = WriteOrder && cnt_down_i.valid && cnt_down_i.rw;
  assign r_inc = ReadOrder && up_accept && !cnt_up_i.rw;
  assign r_dec = ReadOrder && cnt_down_i.valid && !cnt_down_i.rw;

  axi_llc_sat_counter #(
    .Width (OrdWidth)
  ) i_w_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (w_inc),
    .dec_i       (w_dec),
    .q_o         (w_cnt_q_o),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .underflow_o (w_uf)
  );

  axi_llc_sat_counter #(
    .Width (OrdWidth)
  ) i_r_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (r_inc),
    .dec_i       (r_dec),
    .q_o         (r_cnt_q_o),
    .full_o      (r_full),
    .empty_o     (r_empty),
    .underflow_o (r_uf)
  );

  assign idle_o = (&id_empty) && w_empty && r_empty;

  assign underflow_d = underflow_q || (|id_uf) || w_uf || r_uf;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) underflow_q <= 1'b0;
    else         underflow_q <= underflow_d;
  end

  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_axi_llc_miss_cnt_bank.sv
// Bench for the miss counter bank: two instances (ReadOrder off/on) driven in
// lockstep and compared against an arithmetic model of the counting rules.
module tb_axi_llc_miss_cnt_bank;
  import axi_llc_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  miss_cnt_t up, dn;

  logic             to_miss [2];
  logic             stall   [2];
  logic             idle    [2];
  logic             uf      [2];
  logic [3:0][3:0]  cq      [2];
  logic [4:0]       wq      [2];
  logic [4:0]       rq      [2];

  int errors = 0;
  int checks = 0;

  // model state, index 0 = ReadOrder off, 1 = ReadOrder on
  int m_cnt [2][4];
  int m_w   [2];
  int m_r   [2];
  bit m_uf  [2];
  bit wo    [2] = '{1'b1, 1'b1};
  bit ro    [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  axi_llc_miss_cnt_bank #(
    .IdBits(2), .CntWidth(4), .OrdWidth(5), .WriteOrder(1'b1), .ReadOrder(1'b0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cnt_up_i(up), .cnt_down_i(dn),
    .to_miss_o(to_miss[0]), .stall_o(stall[0]), .idle_o(idle[0]),
    .underflow_o(uf[0]), .cnt_q_o(cq[0]), .w_cnt_q_o(wq[0]), .r_cnt_q_o(rq[0])
  );

  axi_llc_miss_cnt_bank #(
    .IdBits(2), .CntWidth(4), .OrdWidth(5), .WriteOrder(1'b1), .ReadOrder(1'b1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cnt_up_i(up), .cnt_down_i(dn),
    .to_miss_o(to_miss[1]), .stall_o(stall[1]), .idle_o(idle[1]),
    .underflow_o(uf[1]), .cnt_q_o(cq[1]), .w_cnt_q_o(wq[1]), .r_cnt_q_o(rq[1])
  );

  function automatic miss_cnt_t mk(bit v, bit rw, int id);
    miss_cnt_t d;
    d.valid = v;
    d.rw    = rw;
    d.id    = 4'(id);
    return d;
  endfunction

  function automatic int idx(miss_cnt_t d);
    return int'(d.id[1:0]);
  endfunction

  function automatic bit exp_stall(int k, miss_cnt_t u);
    return u.valid && (m_cnt[k][idx(u)] == 15 ||
                       ( u.rw && wo[k] && m_w[k] == 31) ||
                       (!u.rw && ro[k] && m_r[k] == 31));
  endfunction

  function automatic bit exp_to_miss(int k, miss_cnt_t u);
    return u.valid && (m_cnt[k][idx(u)] != 0 ||
                       ( u.rw && wo[k] && m_w[k] != 0) ||
                       (!u.rw && ro[k] && m_r[k] != 0));
  endfunction

  function automatic int sat(int v, int delta, int maxv, output bit und);
    und = 1'b0;
    if (delta < 0 && v == 0) begin
      und = 1'b1;
      return 0;
    end
    if (delta > 0 && v == maxv) return v;
    return v + delta;
  endfunction

  task automatic model_reset(int k);
    for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
    m_w[k]  = 0;
    m_r[k]  = 0;
    m_uf[k] = 1'b0;
  endtask

  task automatic model_step(int k, miss_cnt_t u, miss_cnt_t d);
    bit acc, und;
    int dlt;
    acc = u.valid && !exp_stall(k, u);
    for (int i = 0; i < 4; i++) begin
      dlt = 0;
      if (acc && idx(u) == i) dlt++;
      if (d.valid && idx(d) == i) dlt--;
      m_cnt[k][i] = sat(m_cnt[k][i], dlt, 15, und);
      if (und) m_uf[k] = 1'b1;
    end
    if (wo[k]) begin
      dlt = ((acc && u.rw) ? 1 : 0) - ((d.valid && d.rw) ? 1 : 0);
      m_w[k] = sat(m_w[k], dlt, 31, und);
      if (und) m_uf[k] = 1'b1;
    end
    if (ro[k]) begin
      dlt = ((acc && !u.rw) ? 1 : 0) - ((d.valid && !d.rw) ? 1 : 0);
      m_r[k] = sat(m_r[k], dlt, 31, und);
      if (und) m_uf[k] = 1'b1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_comb(string step);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.stall%0d", step, k), 32'(stall[k]), 32'(exp_stall(k, up)));
      check($sformatf("%s.to_miss%0d", step, k), 32'(to_miss[k]), 32'(exp_to_miss(k, up)));
    end
  endtask

  task automatic check_regs(string step);
    bit zero;
    for (int k = 0; k < 2; k++) begin
      zero = (m_w[k] == 0) && (m_r[k] == 0);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s.cnt%0d[%0d]", step, k, i), 32'(cq[k][i]), m_cnt[k][i]);
        if (m_cnt[k][i] != 0) zero = 1'b0;
      end
      check($sformatf("%s.w_cnt%0d", step, k), 32'(wq[k]), m_w[k]);
      check($sformatf("%s.r_cnt%0d", step, k), 32'(rq[k]), m_r[k]);
      check($sformatf("%s.idle%0d", step, k), 32'(idle[k]), 32'(zero));
      check($sformatf("%s.underflow%0d", step, k), 32'(uf[k]), 32'(m_uf[k]));
    end
  endtask

  // Drives one clock cycle; assumed entered just after a rising edge.
  task automatic cycle(miss_cnt_t u, miss_cnt_t d, bit rst, string step);
    up    = u;
    dn    = d;
    rst_n = ~rst;
    #1;
    check_comb(step);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else     model_step(k, u, d);
    end
    #1;
    check_regs(step);
  endtask

  // Combinational look at the outputs without advancing the clock.
  task automatic query(miss_cnt_t u, string step);
    up = u;
    #1;
    check_comb(step);
    up = '0;
    #1;
  endtask

  miss_cnt_t nop;

  initial begin
    nop   = '0;
    up    = '0;
    dn    = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    check_regs("reset");
    check("reset.idle_o", 32'(idle[0]), 1);
    cycle(mk(1, 1, 2), mk(1, 0, 3), 1'b1, "reset_active");
    query(mk(1, 1, 0), "reset_query");

    // fill and drain ID1 with reads
    for (int n = 0; n < 15; n++) cycle(mk(1, 0, 1), nop, 1'b0, "fill");
    check("fill.cnt1", 32'(cq[0][1]), 15);
    check("fill.r_cnt_on", 32'(rq[1]), 15);
    up = mk(1, 0, 1);
    #1;
    check("fill.stall_o", 32'(stall[0]), 1);
    cycle(mk(1, 0, 1), nop, 1'b0, "fill16");
    check("fill16.cnt1", 32'(cq[0][1]), 15);
    cycle(nop, mk(1, 0, 1), 1'b0, "drain1");
    check("drain1.cnt1", 32'(cq[0][1]), 14);
    cycle(mk(1, 0, 1), nop, 1'b0, "refill");
    check("refill.cnt1", 32'(cq[0][1]), 15);

    // simultaneous up and down
    cycle(nop, nop, 1'b1, "rst1");
    for (int n = 0; n < 3; n++) cycle(mk(1, 0, 2), nop, 1'b0, "load2");
    cycle(mk(1, 0, 3), nop, 1'b0, "load3");
    cycle(mk(1, 0, 2), mk(1, 0, 2), 1'b0, "same_id");
    check("same_id.cnt2", 32'(cq[0][2]), 3);
    cycle(mk(1, 0, 0), mk(1, 0, 3), 1'b0, "cross_id");
    check("cross_id.cnt0", 32'(cq[0][0]), 1);
    check("cross_id.cnt3", 32'(cq[0][3]), 0);

    // write ordering
    cycle(nop, nop, 1'b1, "rst2");
    cycle(mk(1, 1, 0), nop, 1'b0, "wr_id0");
    up = mk(1, 1, 3);
    #1;
    check("word.wr_query", 32'(to_miss[0]), 1);
    up = mk(1, 0, 3);
    #1;
    check("word.rd_query", 32'(to_miss[0]), 0);
    query(mk(1, 1, 7), "word_model");

    // read ordering
    cycle(nop, nop, 1'b1, "rst3");
    cycle(mk(1, 0, 1), nop, 1'b0, "rd_id1");
    up = mk(1, 0, 2);
    #1;
    check("rord.on", 32'(to_miss[1]), 1);
    check("rord.off", 32'(to_miss[0]), 0);
    query(mk(1, 0, 6), "rord_model");

    // underflow
    cycle(nop, nop, 1'b1, "rst4");
    cycle(nop, mk(1, 1, 0), 1'b0, "uf_down");
    check("uf.cnt0", 32'(cq[0][0]), 0);
    check("uf.flag", 32'(uf[0]), 1);
    for (int n = 0; n < 3; n++) cycle(nop, nop, 1'b0, "uf_hold");
    check("uf.hold", 32'(uf[0]), 1);

    // reset mid-operation
    cycle(nop, nop, 1'b1, "rst5");
    for (int n = 0; n < 5; n++) cycle(mk(1, 1, 0), nop, 1'b0, "load_a");
    for (int n = 0; n < 7; n++) cycle(mk(1, 0, 1), nop, 1'b0, "load_b");
    cycle(nop, mk(1, 0, 2), 1'b0, "uf_before_rst");
    check("mid.cnt0", 32'(cq[0][0]), 5);
    check("mid.cnt1", 32'(cq[0][1]), 7);
    cycle(mk(1, 1, 0), mk(1, 0, 1), 1'b1, "mid_rst");
    check("mid_rst.idle", 32'(idle[0]), 1);
    check("mid_rst.uf", 32'(uf[0]), 0);
    check("mid_rst.cnt1", 32'(cq[0][1]), 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      miss_cnt_t ru, rd;
      ru = mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      rd = mk($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      cycle(ru, rd, $urandom_range(0, 127) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
